norm_arbiter: RTL and testbench

//   Shares one norm unit (Q16.16 N(d1)/N(d2), start/done handshake) between NREQ

---
 rtl/norm_arbiter.sv | 128 ++++++++++++
 tb/tb_norm_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_arbiter.sv
// Round-robin share of one norm unit between NREQ requesters; one job in flight at a time.
// Latency: ack/norm_start one cycle after req is seen in IDLE, rsp_valid one cycle after done is sampled.
// Backpressure: req is held until ack; requests are only arbitrated in IDLE, so extra requests wait.
module norm_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_d1,
  input  logic [NREQ*WIDTH-1:0] req_d2,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_Nd1,
  output logic [WIDTH-1:0]      rsp_Nd2,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  norm_start,
  output logic [WIDTH-1:0]      norm_d1,
  output logic [WIDTH-1:0]      norm_d2,
  input  logic [WIDTH-1:0]      norm_Nd1,
  input  logic [WIDTH-1:0]      norm_Nd2,
  input  logic                  norm_done
);

  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t        state_q;
  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] owner_q;
  logic [PW-1:0] pick_d;
  logic [WW-1:0] wdog_q;
  logic          wdog_exp;

  assign wdog_exp = (wdog_q == WW'(TIMEOUT));

  // Scan downwards so the last hit is the smallest offset from rr_ptr_q.
  always_comb begin
    logic [PW:0] idx;
    pick_d = rr_ptr_q;
    idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (req[idx[PW-1:0]]) pick_d = idx[PW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      wdog_q     <= '0;
      ack        <= '0;
      rsp_valid  <= '0;
      rsp_Nd1    <= '0;
      rsp_Nd2    <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      norm_start <= 1'b0;
      norm_d1    <= '0;
      norm_d2    <= '0;
    end else begin
      ack        <= '0;
      rsp_valid  <= '0;
      norm_start <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q    <= pick_d;
            norm_d1    <= req_d1[pick_d*WIDTH +: WIDTH];
            norm_d2    <= req_d2[pick_d*WIDTH +: WIDTH];
            norm_start <= 1'b1;
            ack        <= NREQ'(1) << pick_d;
            busy       <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          wdog_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (norm_done) begin
            rsp_Nd1   <= norm_Nd1;
            rsp_Nd2   <= norm_Nd2;
            rsp_err   <= 1'b0;
            rsp_valid <= NREQ'(1) << owner_q;
            state_q   <= RESP;
          end else if (wdog_exp) begin
            rsp_Nd1   <= '0;
            rsp_Nd2   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NREQ'(1) << owner_q;
            state_q   <= RESP;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        RESP: begin
          rr_ptr_q <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
          wdog_q   <= '0;
          state_q  <= DRAIN;
        end
        DRAIN: begin
          // A done still high from this job must fall before the next start.
          if (!norm_done || wdog_exp) begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm_arbiter.sv
// Bench for norm_arbiter: directed scenarios then randomized request sets against a job-level model.
module tb_norm_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_d1;
  logic [N*W-1:0] req_d2;
  logic [N-1:0]   ack;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_Nd1;
  logic [W-1:0]   rsp_Nd2;
  logic           rsp_err;
  logic           busy;
  logic           norm_start;
  logic [W-1:0]   norm_d1;
  logic [W-1:0]   norm_d2;
  logic [W-1:0]   norm_Nd1;
  logic [W-1:0]   norm_Nd2;
  logic           norm_done;

  norm_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_d1(req_d1), .req_d2(req_d2),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_Nd1(rsp_Nd1), .rsp_Nd2(rsp_Nd2),
    .rsp_err(rsp_err), .busy(busy), .norm_start(norm_start),
    .norm_d1(norm_d1), .norm_d2(norm_d2), .norm_Nd1(norm_Nd1),
    .norm_Nd2(norm_Nd2), .norm_done(norm_done)
  );

  int checks, failures, cyc;
  int lat, hold, overlap, starts, ack0_cnt, ptr;
  int t_ack, t_rsp, t_idle;
  bit hung;
  logic [W-1:0] d1 [N];
  logic [W-1:0] d2 [N];
  logic [W-1:0] x1, x2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_d1 = '0;
    req_d2 = '0;
    for (int i = 0; i < N; i++) begin
      req_d1[i*W +: W] = d1[i];
      req_d2[i*W +: W] = d2[i];
    end
  end

  // Stand-in norm transfer: 0.5 + x/4, clamped to [0,1] in Q16.16.
  function automatic logic [W-1:0] nfun(input logic [W-1:0] x);
    longint v;
    v = 64'sd32768 + longint'($signed(x)) / 4;
    if (v < 0) v = 0;
    if (v > 65536) v = 65536;
    return 32'(v);
  endfunction

  function automatic logic [W-1:0] rnd();
    return 32'($urandom_range(0, 32'h0006_0000)) - 32'h0003_0000;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Norm unit stand-in: done rises lat+1 cycles after start, stays high hold cycles.
  bit run;
  int cnt, hcnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run <= 1'b0; cnt <= 0; hcnt <= 0;
      norm_done <= 1'b0; norm_Nd1 <= '0; norm_Nd2 <= '0;
    end else if (norm_start) begin
      if (run) overlap <= overlap + 1;
      norm_Nd1  <= nfun(norm_d1);
      norm_Nd2  <= nfun(norm_d2);
      norm_done <= 1'b0;
      run       <= !hung;
      cnt       <= lat;
    end else if (run) begin
      if (cnt <= 1) begin
        run <= 1'b0; norm_done <= 1'b1; hcnt <= hold;
      end else cnt <= cnt - 1;
    end else if (norm_done) begin
      if (hcnt <= 1) norm_done <= 1'b0;
      else hcnt <= hcnt - 1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (norm_start) starts <= starts + 1;
    if (ack[0]) ack0_cnt <= ack0_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_Nd1"}, rsp_Nd1, 0);
    chk({tag, "_rsp_Nd2"}, rsp_Nd2, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_norm_start"}, norm_start, 0);
    chk({tag, "_norm_d1"}, norm_d1, 0);
    chk({tag, "_norm_d2"}, norm_d2, 0);
  endtask

  task automatic wait_ack(input int e, input bit keep);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (ack != 0) seen = 1'b1;
    end
    chk("ack_seen", seen, 1);
    chk("ack_who", ack, 64'd1 << e);
    chk("start_with_ack", norm_start, 1);
    chk("busy_at_ack", busy, 1);
    x1 = d1[e];
    x2 = d2[e];
    chk("norm_d1", norm_d1, x1);
    chk("norm_d2", norm_d2, x2);
    t_ack = cyc;
    if (keep) begin
      d1[e] = rnd();
      d2[e] = rnd();
    end else req[e] = 1'b0;
  endtask

  task automatic wait_rsp(input int e, input bit err);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) seen = 1'b1;
    end
    t_rsp = cyc;
    chk("rsp_seen", seen, 1);
    chk("rsp_who", rsp_valid, 64'd1 << e);
    chk("rsp_err", rsp_err, err);
    chk("rsp_Nd1", rsp_Nd1, err ? 32'd0 : nfun(x1));
    chk("rsp_Nd2", rsp_Nd2, err ? 32'd0 : nfun(x2));
    chk("ack_to_rsp", t_rsp - t_ack, err ? TO + 2 : lat + 2);
    ptr = (e + 1) % N;
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    t_idle = cyc;
    chk("idle_seen", seen, 1);
  endtask

  task automatic do_job(input int e, input bit err, input bit keep);
    wait_ack(e, keep);
    wait_rsp(e, err);
    wait_idle();
  endtask

  initial begin
    logic [N-1:0] rs;
    int e, n, s0, a0, late;
    bit kp;
    reset_n = 1'b0; req = '0; hung = 1'b0; lat = 2; hold = 1; ptr = 0;
    for (int i = 0; i < N; i++) begin d1[i] = '0; d2[i] = '0; end
    repeat (3) @(negedge clk);
    outs_zero("rst");
    reset_n = 1'b1;

    // single request, zero operands give 0.5
    @(negedge clk);
    req = 4'b0001;
    do_job(0, 0, 0);
    chk("t1_Nd1_half", rsp_Nd1, 32'h0000_8000);
    chk("t1_Nd2_half", rsp_Nd2, 32'h0000_8000);

    // all four requesting from a fresh pointer: served 0,1,2,3
    reset_n = 1'b0; ptr = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin d1[i] = 32'(i) << 16; d2[i] = 32'(i) << 16; end
    req = 4'b1111;
    for (int i = 0; i < N; i++) do_job(i, 0, 0);

    // two requesters held continuously alternate
    req = 4'b1010;
    for (int k = 0; k < 4; k++) do_job((k % 2 == 0) ? 1 : 3, 0, 1);
    req = '0;

    // hung norm: timeout abort, then the next request is served normally
    hung = 1'b1; d1[2] = rnd(); d2[2] = rnd();
    req = 4'b0100;
    do_job(2, 1, 0);
    hung = 1'b0;
    req = 4'b0100;
    do_job(2, 0, 0);

    // reset mid-WAIT aborts the job and returns the pointer to 0
    lat = 10;
    req = 4'b1000;
    wait_ack(3, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 outs_zero("t5");
    ptr = 0;
    @(negedge clk);
    reset_n = 1'b1;
    late = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid != 0) late++;
    end
    chk("t5_no_rsp", late, 0);
    lat = 3;
    req = 4'b1100;
    do_job(rr_pick(4'b1100, ptr), 0, 0);
    do_job(3, 0, 0);

    // a one-cycle request while busy is never granted
    req = 4'b0010;
    wait_ack(1, 0);
    @(negedge clk);
    s0 = starts; a0 = ack0_cnt;
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    wait_rsp(1, 0);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("t6_no_start", starts - s0, 0);
    chk("t6_no_ack0", ack0_cnt - a0, 0);

    // done held past DRAIN: watchdog exit, then stale done ignored by the next job
    hold = TO + 8; lat = 2;
    req = 4'b0001;
    do_job(0, 0, 0);
    chk("t7_drain_timeout", t_idle - t_rsp, TO + 2);
    chk("t7_done_still_high", norm_done, 1);
    hold = 1;
    req = 4'b0010;
    do_job(1, 0, 0);

    // randomized request sets, operands and norm timing
    for (int r = 0; r < 30; r++) begin
      rs = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin d1[i] = rnd(); d2[i] = rnd(); end
      lat = $urandom_range(1, 5); hold = $urandom_range(1, 3);
      n = 0;
      req = rs;
      while (rs != 0 && n < 6) begin
        e = rr_pick(rs, ptr);
        kp = ($urandom_range(0, 3) == 0);
        do_job(e, 0, kp);
        if (!kp) rs[e] = 1'b0;
        n++;
        lat = $urandom_range(1, 5); hold = $urandom_range(1, 3);
      end
      req = '0;
    end
    chk("no_start_while_running", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
